// File: rtl/mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_ctrl_if
//   Cache-side request/response bundle of the line-granular memory controller.
//
//   Handshake: a request transfers on a rising clk edge where req_valid and
//   req_ready are both 1. req_valid and the payload (req_write, req_addr,
//   req_be, req_wd) are held by the cache until that edge. req_ready may
//   depend combinationally on req_write. wr_ack and rsp_valid are
//   single-cycle pulses with no back-pressure.
//
//   Signals:
//     req_valid  cache -> ctrl  request valid
//     req_ready  ctrl  -> cache controller can take the request this cycle
//     req_write  cache -> ctrl  1 = line writeback, 0 = line fill read
//     req_addr   cache -> ctrl  line index (32b)
//     req_be     cache -> ctrl  byte enables for writeback (32b)
//     req_wd     cache -> ctrl  writeback data (256b)
//     wr_ack     ctrl  -> cache writeback taken into the buffer (pulse)
//     rsp_valid  ctrl  -> cache fill data valid (pulse)
//     rsp_rd     ctrl  -> cache fill data, 0 when rsp_valid=0 (256b)
//     rsp_err    ctrl  -> cache with rsp_valid: read timed out
// -----------------------------------------------------------------------------
interface mem_ctrl_if;
   logic         req_valid;
   logic         req_ready;
   logic         req_write;
   logic [31:0]  req_addr;
   logic [31:0]  req_be;
   logic [255:0] req_wd;
   logic         wr_ack;
   logic         rsp_valid;
   logic [255:0] rsp_rd;
   logic         rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_be, req_wd,
      input  req_ready, wr_ack, rsp_valid, rsp_rd, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_be, req_wd,
      output req_ready, wr_ack, rsp_valid, rsp_rd, rsp_err
   );
endinterface

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
//   Line-granular controller between the L1 fill/evict port and main memory.
//   Writebacks are posted into a 1-entry buffer and acknowledged early; the
//   buffer drains with an address cycle followed by a write cycle. Fills are
//   issued as a single read pulse and returned once memory signals valid, or
//   with rsp_err after READ_TIMEOUT cycles of waiting. A buffered write always
//   drains before a read is issued.
//
//   Ports:
//     clk        in   clock, all state on posedge
//     rst_n      in   asynchronous active-low reset
//     bus        slave modport of mem_ctrl_if (cache request/response side)
//     mem_a      out  memory line address (32b)
//     mem_be     out  memory byte enables, 0 outside the write cycle (32b)
//     mem_wd     out  memory write data, 0 outside the write cycle (256b)
//     mem_write  out  memory write strobe
//     mem_read   out  memory read strobe (single-cycle pulse)
//     mem_rd     in   memory read data (256b)
//     mem_valid  in   memory read data valid
//     dbg_state  out  current FSM state (state_t encoding)
// -----------------------------------------------------------------------------
module mem_ctrl #(
   parameter int READ_TIMEOUT = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   mem_ctrl_if.slave    bus,
   output logic [31:0]  mem_a,
   output logic [31:0]  mem_be,
   output logic [255:0] mem_wd,
   output logic         mem_write,
   output logic         mem_read,
   input  logic [255:0] mem_rd,
   input  logic         mem_valid,
   output logic [2:0]   dbg_state
);

   localparam int TW = $clog2(READ_TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WR_ADDR  = 3'd1,
      WR_DATA  = 3'd2,
      RD_ISSUE = 3'd3,
      RD_WAIT  = 3'd4,
      RESP     = 3'd5
   } state_t;

   state_t         state;
   logic           wb_valid;
   logic           rd_pend;
   logic [TW-1:0]  timer;
   logic [31:0]    buf_addr;
   logic [31:0]    buf_be;
   logic [255:0]   buf_wd;
   logic [31:0]    rd_addr;
   logic           wr_ack_q;
   logic           rsp_valid_q;
   logic [255:0]   rsp_rd_q;
   logic           rsp_err_q;
   logic           req_ready;
   logic           accept;

   // Only one read may be outstanding, and a second write must wait for the
   // buffer to drain. A read is still accepted while a write is buffered.
   assign req_ready = (state == IDLE) && !rd_pend && (!bus.req_write || !wb_valid);
   assign accept    = bus.req_valid && req_ready;

   assign bus.req_ready = req_ready;
   assign bus.wr_ack    = wr_ack_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rd    = rsp_rd_q;
   assign bus.rsp_err   = rsp_err_q;
   assign dbg_state     = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         wb_valid    <= 1'b0;
         rd_pend     <= 1'b0;
         timer       <= '0;
         buf_addr    <= '0;
         buf_be      <= '0;
         buf_wd      <= '0;
         rd_addr     <= '0;
         mem_a       <= '0;
         mem_be      <= '0;
         mem_wd      <= '0;
         mem_write   <= 1'b0;
         mem_read    <= 1'b0;
         wr_ack_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rd_q    <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         // Strobes and pulses are asserted only on the transition into the
         // state that owns them, so they default low every cycle.
         wr_ack_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rd_q    <= '0;
         rsp_err_q   <= 1'b0;
         mem_write   <= 1'b0;
         mem_read    <= 1'b0;
         mem_be      <= '0;
         mem_wd      <= '0;

         // Acceptance only happens in IDLE, so it never collides with the
         // clears of wb_valid (WR_DATA) or rd_pend (RESP).
         if (accept) begin
            if (bus.req_write) begin
               buf_addr <= bus.req_addr;
               buf_be   <= bus.req_be;
               buf_wd   <= bus.req_wd;
               wb_valid <= 1'b1;
               wr_ack_q <= 1'b1;
            end else begin
               rd_addr <= bus.req_addr;
               rd_pend <= 1'b1;
            end
         end

         case (state)
            IDLE: begin
               // Decisions use the registered flags, so a request accepted
               // this cycle is acted on next cycle. Writes win over reads.
               mem_a <= '0;
               if (wb_valid) begin
                  state <= WR_ADDR;
                  mem_a <= buf_addr;
               end else if (rd_pend) begin
                  state    <= RD_ISSUE;
                  mem_a    <= rd_addr;
                  mem_read <= 1'b1;
               end
            end

            WR_ADDR: begin
               state     <= WR_DATA;
               mem_write <= 1'b1;
               mem_be    <= buf_be;
               mem_wd    <= buf_wd;
            end

            WR_DATA: begin
               wb_valid <= 1'b0;
               state    <= IDLE;
               mem_a    <= '0;
            end

            RD_ISSUE: begin
               timer <= '0;
               state <= RD_WAIT;
            end

            RD_WAIT: begin
               if (timer != {TW{1'b1}}) begin
                  timer <= timer + 1'b1;
               end
               if (mem_valid) begin
                  state       <= RESP;
                  mem_a       <= '0;
                  rsp_valid_q <= 1'b1;
                  rsp_rd_q    <= mem_rd;
               end else if (timer == TW'(READ_TIMEOUT - 1)) begin
                  state       <= RESP;
                  mem_a       <= '0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
               end
            end

            RESP: begin
               rd_pend <= 1'b0;
               state   <= IDLE;
            end

            default: begin
               state <= IDLE;
               mem_a <= '0;
            end
         endcase
      end
   end

endmodule
